// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and control states shared by alu_pipe and its multiplier
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_NOT,
    OP_SHL, OP_SHR, OP_SRA, OP_PASS, OP_MUL
  } op_e;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL_BUSY, ST_HOLD} state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one partial-product bit per cycle, done after WIDTH cycles
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  assign done = run_q && cnt_q == CW'(WIDTH);
  assign product = acc_q;
  // bit 0 is folded in on the start edge so the product is complete after WIDTH cycles
  always_comb begin
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      acc_d = b[0] ? a : '0;
      mcand_d = a << 1;
      mplier_d = b >> 1;
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (done) begin
      run_d = 1'b0;
    end else if (run_q) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end
  // iteration registers; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags; ALU_PIPE_MUL_EN adds a sequential MUL (opcode 12)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, res_c, res_s, sub_w, mul_p;
  logic [3:0] flags_q, flags_d, flg_s;
  logic illegal_q, illegal_d, c_c, v_c, ill_c, ill_s, is_mul, busy, accept, op_hi, mul_done;
  logic [WIDTH:0] add_w, shl_w, shr_w, sra_w;
  logic signed [WIDTH:0] a_ext;
  logic [SHW-1:0] sh;
  op_e op;
  assign op = op_e'(opcode[3:0]);
  assign op_hi = (opcode >> 4) != '0;
  assign sh = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = a - b;
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign a_ext = {a, 1'b0};
  assign sra_w = a_ext >>> sh;
  assign busy = state_q == ST_MUL_BUSY;
  assign out_valid = state_q == ST_HOLD;
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign result = result_q;
  assign flags = flags_q;
  assign illegal = illegal_q;
`ifdef ALU_PIPE_MUL_EN
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start(accept && is_mul), .a(a), .b(b),
    .done(mul_done), .product(mul_p)
  );
`else
  assign mul_done = 1'b0;
  assign mul_p = '0;
`endif
  // opcode decode: single-cycle result plus carry/overflow; the widened shifts expose the last bit out
  always_comb begin
    res_c = '0;
    c_c = 1'b0;
    v_c = 1'b0;
    ill_c = 1'b0;
    is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = add_w[WIDTH-1:0];
        c_c = add_w[WIDTH];
        v_c = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = sub_w;
        c_c = a < b;
        v_c = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_NAND: res_c = ~(a & b);
      OP_NOR:  res_c = ~(a | b);
      OP_NOT:  res_c = ~a;
      OP_SHL:  {c_c, res_c} = shl_w;
      OP_SHR:  {res_c, c_c} = shr_w;
      OP_SRA:  {res_c, c_c} = sra_w;
      OP_PASS: res_c = b;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
    if (op_hi) begin
      res_c = '0;
      c_c = 1'b0;
      v_c = 1'b0;
      ill_c = 1'b1;
      is_mul = 1'b0;
    end
  end
  // one flag generator serves both the ALU and the multiplier result; illegal ops clear everything
  always_comb begin
    res_s = busy ? mul_p : res_c;
    ill_s = !busy && ill_c;
    flg_s = '0;
    flg_s[FLAG_Z] = res_s == '0;
    flg_s[FLAG_N] = res_s[WIDTH-1];
    flg_s[FLAG_C] = !busy && c_c;
    flg_s[FLAG_V] = !busy && v_c;
    if (ill_s) flg_s = '0;
  end
  // handshake control: load on finished op, start multiply, or drain the output stage
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    flags_d = flags_q;
    illegal_d = illegal_q;
    if (busy ? mul_done : accept && !is_mul) begin
      state_d = ST_HOLD;
      result_d = res_s;
      flags_d = flg_s;
      illegal_d = ill_s;
    end else if (accept) begin
      state_d = ST_MUL_BUSY;
    end else if (out_valid && out_ready) begin
      state_d = ST_IDLE;
    end
  end
  // state and output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      result_q <= '0;
      flags_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      flags_q <= flags_d;
      illegal_q <= illegal_d;
    end
  end
endmodule
